// File: rtl/audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// audio_dac_serializer
//
// Codec-facing end of the audio write path. Stereo sample pairs arrive in
// parallel from user logic and are buffered in a small FIFO. Each pair is then
// shifted out MSB first on AUD_DACDAT. The framing comes from the codec-mastered
// bit clock (AUD_BCLK) and frame clock (AUD_DACLRCK). All logic runs on the
// rising edge of CLOCK_50.
//
// Handshake: a pair is accepted on any CLOCK_50 edge where write && write_ready.
// write_ready is combinational and low only while the FIFO is full. A write
// presented while full is dropped.
//
// Ports:
//   CLOCK_50         system clock
//   reset            synchronous, active-high reset
//   write            push request for one sample pair
//   writedata_left   left-channel sample
//   writedata_right  right-channel sample
//   write_ready      FIFO can accept a pair
//   AUD_BCLK         codec bit clock (asynchronous)
//   AUD_DACLRCK      codec frame clock (asynchronous), 0 = left, 1 = right
//   AUD_DACDAT       registered serial data to the codec
//   fifo_level       number of occupied FIFO entries
//   underflow        sticky: a frame started while the FIFO was empty
// -----------------------------------------------------------------------------
module audio_dac_serializer #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 8,
  parameter int I2S_DELAY  = 1
) (
  input  logic                          CLOCK_50,
  input  logic                          reset,
  input  logic                          write,
  input  logic [DATA_WIDTH-1:0]         writedata_left,
  input  logic [DATA_WIDTH-1:0]         writedata_right,
  output logic                          write_ready,
  input  logic                          AUD_BCLK,
  input  logic                          AUD_DACLRCK,
  output logic                          AUD_DACDAT,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          underflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  localparam logic [1:0] ST_WAIT  = 2'd0;
  localparam logic [1:0] ST_DELAY = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;
  localparam logic [1:0] ST_PAD   = 2'd3;

  // Input synchronizers. The BCLK history flop gives edge detection. LRCK is
  // only ever examined on a BCLK fall, and lrck_prev_q is the history it is
  // compared against.
  logic bclk_s1_q, bclk_s2_q, bclk_s3_q;
  logic lrck_s1_q, lrck_s2_q;
  logic lrck_prev_q, lrck_prev_d;

  // FIFO
  logic [2*DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [LW-1:0]           level_q, level_d;
  logic                    fifo_empty, push, pop;
  logic [2*DATA_WIDTH-1:0] rd_word;

  // Serializer
  logic [1:0]            state_q, state_d, slot_state;
  logic [DATA_WIDTH-1:0] left_sr_q, left_sr_d, right_sr_q, right_sr_d;
  logic [DATA_WIDTH-1:0] load_l, load_r, shift_word;
  logic [CW-1:0]         cnt_q, cnt_d, slot_cnt, cnt_inc;
  logic                  sel_q, sel_d, slot_sel;
  logic                  dac_q, dac_d;
  logic                  underflow_q, underflow_d;

  logic bclk_fall, boundary, left_bnd;

  // Falling BCLK: the synchronized level has just gone low while the
  // history flop still holds the old high level.
  assign bclk_fall = ~bclk_s2_q & bclk_s3_q;
  assign boundary  = bclk_fall & (lrck_s2_q != lrck_prev_q);
  assign left_bnd  = boundary & ~lrck_s2_q;

  assign fifo_empty  = (level_q == '0);
  assign write_ready = (level_q != LW'(FIFO_DEPTH));
  assign push        = write & write_ready;
  // Pop uses only the registered level, so a coincident push is never bypassed.
  assign pop         = left_bnd & ~fifo_empty;
  assign rd_word     = mem_q[rd_ptr_q];

  assign AUD_DACDAT = dac_q;
  assign fifo_level = level_q;
  assign underflow  = underflow_q;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // The "slot" state is the state that owns the current BCLK fall. A boundary
  // redirects the slot to DELAY (I2S) or SHIFT (left-justified), so the
  // boundary fall itself emits the I2S delay bit or the left-justified MSB.
  always_comb begin
    lrck_prev_d = lrck_prev_q;
    left_sr_d   = left_sr_q;
    right_sr_d  = right_sr_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    dac_d       = dac_q;
    underflow_d = underflow_q;
    load_l      = left_sr_q;
    load_r      = right_sr_q;
    slot_state  = state_q;
    slot_cnt    = cnt_q;
    slot_sel    = sel_q;
    shift_word  = '0;
    cnt_inc     = '0;

    if (bclk_fall) begin
      lrck_prev_d = lrck_s2_q;

      // Frame load happens on every left boundary, including the one that
      // leaves WAIT_SYNC.
      if (left_bnd) begin
        if (fifo_empty) begin
          load_l      = '0;
          load_r      = '0;
          underflow_d = 1'b1;
        end else begin
          load_l = rd_word[2*DATA_WIDTH-1:DATA_WIDTH];
          load_r = rd_word[DATA_WIDTH-1:0];
        end
      end

      // WAIT_SYNC only reacts to a left boundary; other states to any.
      if (boundary && ((state_q != ST_WAIT) || left_bnd)) begin
        slot_state = (I2S_DELAY != 0) ? ST_DELAY : ST_SHIFT;
        slot_cnt   = '0;
        slot_sel   = lrck_s2_q;
      end

      left_sr_d  = load_l;
      right_sr_d = load_r;
      sel_d      = slot_sel;
      cnt_d      = slot_cnt;

      case (slot_state)
        ST_DELAY: begin
          dac_d   = 1'b0;
          state_d = ST_SHIFT;
        end
        ST_SHIFT: begin
          shift_word = slot_sel ? load_r : load_l;
          dac_d      = shift_word[DATA_WIDTH-1];
          if (slot_sel) right_sr_d = shift_word << 1;
          else          left_sr_d  = shift_word << 1;
          cnt_inc = slot_cnt + 1'b1;
          cnt_d   = cnt_inc;
          state_d = (cnt_inc == CW'(DATA_WIDTH)) ? ST_PAD : ST_SHIFT;
        end
        ST_PAD: begin
          dac_d   = 1'b0;
          state_d = ST_PAD;
        end
        default: begin
          dac_d   = 1'b0;
          state_d = ST_WAIT;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      bclk_s1_q   <= 1'b0;
      bclk_s2_q   <= 1'b0;
      bclk_s3_q   <= 1'b0;
      lrck_s1_q   <= 1'b0;
      lrck_s2_q   <= 1'b0;
      lrck_prev_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      state_q     <= ST_WAIT;
      left_sr_q   <= '0;
      right_sr_q  <= '0;
      cnt_q       <= '0;
      sel_q       <= 1'b0;
      dac_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      bclk_s1_q   <= AUD_BCLK;
      bclk_s2_q   <= bclk_s1_q;
      bclk_s3_q   <= bclk_s2_q;
      lrck_s1_q   <= AUD_DACLRCK;
      lrck_s2_q   <= lrck_s1_q;
      lrck_prev_q <= lrck_prev_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q     <= level_d;
      state_q     <= state_d;
      left_sr_q   <= left_sr_d;
      right_sr_q  <= right_sr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      dac_q       <= dac_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge CLOCK_50) begin
    if (push && !reset) mem_q[wr_ptr_q] <= {writedata_left, writedata_right};
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// -----------------------------------------------------------------------------
// tb_audio_dac_serializer
//
// Two instances share clock, reset, write port and codec clocks: one in I2S
// mode, one left-justified. A sample-level model (a queue of pairs plus the
// current frame and bit position) predicts every serial bit, the FIFO level
// and the underflow flag.
// -----------------------------------------------------------------------------
module tb_audio_dac_serializer;
  localparam int W = 24;
  localparam int D = 8;

  // clock / reset
  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic         rst, wr, bclk, lrck;
  logic [W-1:0] wl, wrd;
  logic         rdy1, dac1, und1, rdy0, dac0, und0;
  logic [3:0]   lvl1, lvl0;

  audio_dac_serializer #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .I2S_DELAY(1)) u_i2s (
    .CLOCK_50(clk), .reset(rst), .write(wr), .writedata_left(wl),
    .writedata_right(wrd), .write_ready(rdy1), .AUD_BCLK(bclk),
    .AUD_DACLRCK(lrck), .AUD_DACDAT(dac1), .fifo_level(lvl1), .underflow(und1)
  );

  audio_dac_serializer #(.DATA_WIDTH(W), .FIFO_DEPTH(D), .I2S_DELAY(0)) u_lj (
    .CLOCK_50(clk), .reset(rst), .write(wr), .writedata_left(wl),
    .writedata_right(wrd), .write_ready(rdy0), .AUD_BCLK(bclk),
    .AUD_DACLRCK(lrck), .AUD_DACDAT(dac0), .fifo_level(lvl0), .underflow(und0)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model
  logic [2*W-1:0] m_q[$];
  bit             m_sync, m_under, m_ch, m_prev;
  logic [W-1:0]   m_l, m_r;
  int             m_pos;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [W-1:0] s, input int pos, input bit i2s);
    if (i2s) return (pos >= 1 && pos <= W) ? s[W-pos] : 1'b0;
    else     return (pos < W) ? s[W-1-pos] : 1'b0;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_sync = 0; m_under = 0; m_ch = 0; m_prev = 0;
    m_l = '0; m_r = '0; m_pos = 0;
  endtask

  task automatic model_push(input logic [W-1:0] l, input logic [W-1:0] r);
    if (m_q.size() < D) m_q.push_back({l, r});
  endtask

  // One BCLK fall carrying frame clock level lr.
  task automatic model_fall(input bit lr);
    if (lr != m_prev) begin
      if (!lr) begin
        if (m_q.size() > 0) {m_l, m_r} = m_q.pop_front();
        else begin m_l = '0; m_r = '0; m_under = 1; end
        m_sync = 1;
      end
      if (m_sync) begin m_ch = lr; m_pos = 0; end
    end else begin
      m_pos++;
    end
    m_prev = lr;
  endtask

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; wr = 1'b1; wl = W'($urandom); wrd = W'($urandom);
    @(negedge clk);
    @(negedge clk);
    wr = 1'b0;
    model_reset();
    check("rst_dac_i2s", dac1, 0);
    check("rst_dac_lj", dac0, 0);
    check("rst_level", lvl1, 0);
    check("rst_underflow", und1, 0);
    check("rst_ready", rdy1, 1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_write_ignored", lvl0, 0);
  endtask

  task automatic push(input logic [W-1:0] l, input logic [W-1:0] r);
    @(negedge clk);
    wr = 1'b1; wl = l; wrd = r;
    check("write_ready", rdy1, (m_q.size() != D));
    @(negedge clk);
    wr = 1'b0;
    model_push(l, r);
    check("push_level", lvl1, m_q.size());
  endtask

  task automatic slot(input bit lr, input bit wr_pop, input logic [W-1:0] pl, input logic [W-1:0] pr);
    bit full_before;
    logic [W-1:0] s;
    @(negedge clk);
    bclk = 1'b0; lrck = lr;
    @(negedge clk);
    @(negedge clk);
    if (wr_pop) begin wr = 1'b1; wl = pl; wrd = pr; end
    @(negedge clk);
    wr = 1'b0;
    full_before = (m_q.size() == D);
    model_fall(lr);
    if (wr_pop && !full_before) model_push(pl, pr);
    s = m_ch ? m_r : m_l;
    check("dac_i2s", dac1, m_sync ? exp_bit(s, m_pos, 1) : 1'b0);
    check("dac_lj", dac0, m_sync ? exp_bit(s, m_pos, 0) : 1'b0);
    check("level", lvl1, m_q.size());
    check("level_lj", lvl0, m_q.size());
    check("underflow", und1, m_under);
    check("underflow_lj", und0, m_under);
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic frame(input int n, input bit wr_first, input logic [W-1:0] pl, input logic [W-1:0] pr);
    for (int ch = 0; ch < 2; ch++)
      for (int i = 0; i < n; i++)
        slot(ch[0], (ch == 0 && i == 0) ? wr_first : 1'b0, pl, pr);
  endtask

  initial begin
    bclk = 1'b1; lrck = 1'b1; rst = 1'b0; wr = 1'b0; wl = '0; wrd = '0;
    model_reset();

    // reset state, lead-in while frame clock is high
    do_reset();
    slot(1, 0, '0, '0);
    slot(1, 0, '0, '0);

    // first pair, I2S framing with 32 BCLK per channel
    push(24'hA5A5A5, 24'h3C3C3C);
    frame(32, 0, '0, '0);

    // fill FIFO, ninth write dropped
    for (int k = 0; k < 9; k++) push(W'($urandom), W'($urandom));
    check("full_level", lvl1, D);
    check("full_ready", rdy1, 0);
    for (int k = 0; k < 8; k++) frame(32, 0, '0, '0);

    // empty FIFO: silent frame, sticky underflow
    frame(32, 0, '0, '0);
    push(W'($urandom), W'($urandom));
    check("underflow_sticky", und1, 1);
    do_reset();

    // left-justified MSB on the boundary
    slot(1, 0, '0, '0);
    push(24'h800001, W'($urandom));
    frame(32, 0, '0, '0);

    // short frame, then a normal one
    push(24'hFFFFFF, W'($urandom));
    push(W'($urandom), W'($urandom));
    frame(16, 0, '0, '0);
    frame(32, 0, '0, '0);

    // reset in the middle of the left channel
    push(W'($urandom), W'($urandom));
    for (int i = 0; i < 5; i++) slot(0, 0, '0, '0);
    do_reset();
    push(W'($urandom), W'($urandom));
    for (int i = 0; i < 3; i++) slot(0, 0, '0, '0);
    for (int i = 0; i < 3; i++) slot(1, 0, '0, '0);
    frame(32, 0, '0, '0);
    // write at the exact pop cycle with the FIFO empty
    frame(32, 1, W'($urandom), W'($urandom));
    check("pop_cycle_underflow", und1, 1);
    frame(32, 0, '0, '0);

    // randomized frames and pushes
    for (int f = 0; f < 6; f++) begin
      int np;
      np = $urandom_range(0, 2);
      for (int k = 0; k < np; k++) push(W'($urandom), W'($urandom));
      frame($urandom_range(20, 34), 1'($urandom_range(0, 1)), W'($urandom), W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
